// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and alu_op codes for cpu_step_ctrl
package cpu_pkg;

  // FSM state codes, also shown on the trainer LEDs
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // instruction opcodes in IR[7:6]
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LDI  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // ALU operation codes driven while reg_we is high
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  // fields captured from IR in DECODE
  typedef struct packed {
    logic [1:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
  } decode_t;

  function automatic logic [1:0] alu_of(input logic [1:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_LDI:  alu_of = ALU_PASS;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// rtl/cpu_step_ctrl_debounce.sv - level debouncer with one-cycle rising-edge pulse
module btn_debounce #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [CNT_W-1:0] cnt;

  // count consecutive samples that disagree with the accepted level; any agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= din;
        rise  <= din;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - single-step / free-run fetch-decode-execute sequencer
module cpu_step_ctrl
  import cpu_pkg::*;
#(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_btn,
  input  logic       run_mode,
  input  logic [7:0] instr,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       reg_we,
  output logic [1:0] reg_waddr,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       halted,
  output logic [7:0] instr_count
);

  logic       sync1;
  logic       sync2;
  logic       btn_level;
  logic       step_pulse;
  logic [2:0] st;
  logic [7:0] ir;
  decode_t    dec;
  logic [7:0] count;

  // the datapath reads rs and the immediate from its own IR copy; the level itself is not needed here
  logic unused_bits;
  assign unused_bits = ^{btn_level, dec.rs, ir[1:0]};

  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
    end
  end

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_db (
    .clk  (clk),
    .rst  (rst),
    .din  (sync2),
    .level(btn_level),
    .rise (step_pulse)
  );

  // sequencer: step pulses are only honoured in IDLE, so presses elsewhere are simply dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= ST_IDLE;
      ir    <= '0;
      dec   <= '0;
      count <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (step_pulse || run_mode) st <= ST_FETCH;
        end
        ST_FETCH: begin
          ir <= instr;
          st <= ST_DECODE;
        end
        ST_DECODE: begin
          dec.opcode <= ir[7:6];
          dec.rd     <= ir[5:4];
          dec.rs     <= ir[3:2];
          st         <= (ir[7:6] == OP_HALT) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          count <= count + 8'd1;
          st    <= run_mode ? ST_FETCH : ST_IDLE;
        end
        ST_HALT: st <= ST_HALT;
        default: st <= ST_IDLE;
      endcase
    end
  end

  // all outputs decode from registered state only
  assign state       = st;
  assign ir_load     = (st == ST_FETCH);
  assign reg_we      = (st == ST_EXEC);
  assign pc_inc      = (st == ST_EXEC);
  assign reg_waddr   = (st == ST_EXEC) ? dec.rd : 2'b00;
  assign alu_op      = (st == ST_EXEC) ? alu_of(dec.opcode) : ALU_ADD;
  assign halted      = (st == ST_HALT);
  assign instr_count = count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - scoreboard bench for cpu_step_ctrl with randomized steps
module tb_cpu_step_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_btn;
  logic       run_mode;
  logic [7:0] instr;
  logic       ir_load;
  logic       pc_inc;
  logic       reg_we;
  logic [1:0] reg_waddr;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       halted;
  logic [7:0] instr_count;

  cpu_step_ctrl #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_btn   (step_btn),
    .run_mode   (run_mode),
    .instr      (instr),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .alu_op     (alu_op),
    .state      (state),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [1:0] waddr;
    logic [1:0] op;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       got_e;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_irl = 0;
  logic [7:0] model_cnt;
  int         c0;
  int         irl0;
  logic [7:0] v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitor: pops one expectation for every reg_we strobe the DUT presents
  always @(negedge clk) begin
    if (ir_load) n_irl++;
    if (!rst) begin
      check("pc_inc_with_reg_we", pc_inc, reg_we);
      check("ir_load_reg_we_exclusive", ir_load & reg_we, 0);
    end
    if (reg_we) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_reg_we: got strobe at cycle %0d required none", cyc);
      end else begin
        got_e = sb.pop_front();
        check("reg_we_cycle", cyc, got_e.at);
        check("reg_waddr", reg_waddr, got_e.waddr);
        check("alu_op", alu_op, got_e.op);
        check("count_at_exec", instr_count, got_e.cnt);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step_btn = 1'b0;
    run_mode = 1'b0;
    tick(2);
    rst = 1'b0;
    model_cnt = 8'd0;
    sb.delete();
  endtask

  // one press: optional sub-threshold glitches, then a clean hold of 'hold' cycles
  task automatic step_instr(input logic [7:0] val, input int hold, input int glitches);
    int   irl_s;
    exp_t e;
    instr = val;
    irl_s = n_irl;
    for (int g = 0; g < glitches; g++) begin
      step_btn = 1'b1;
      tick($urandom_range(1, DB - 1));
      step_btn = 1'b0;
      tick($urandom_range(1, 2));
    end
    // 2 sync flops + DB stable samples + FETCH/DECODE/EXEC
    e.at    = cyc + 5 + DB;
    e.waddr = val[5:4];
    e.op    = val[7:6];
    e.cnt   = model_cnt;
    sb.push_back(e);
    model_cnt = model_cnt + 8'd1;
    step_btn = 1'b1;
    tick(hold);
    step_btn = 1'b0;
    tick(DB + 10);
    check("step_sb_drained", sb.size(), 0);
    check("step_ir_load_once", n_irl - irl_s, 1);
    check("step_back_to_idle", state, 0);
    check("step_instr_count", instr_count, model_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    step_btn = 1'b0;
    run_mode = 1'b0;
    instr = 8'h00;
    model_cnt = 8'd0;

    do_reset();
    check("rst_state", state, 0);
    check("rst_ir_load", ir_load, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_waddr", reg_waddr, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_halted", halted, 0);
    check("rst_count", instr_count, 0);

    // LDI r1,2 held 10 cycles
    step_instr(8'h92, 10, 0);

    // bounce 1-0-1 at 2-cycle spacing, then hold
    instr = 8'h14;
    irl0 = n_irl;
    step_btn = 1'b1; tick(2);
    step_btn = 1'b0; tick(2);
    sb.push_back('{at: cyc + 5 + DB, waddr: 2'd1, op: 2'd0, cnt: model_cnt});
    model_cnt = model_cnt + 8'd1;
    step_btn = 1'b1; tick(10);
    step_btn = 1'b0; tick(DB + 10);
    check("bounce_sb_drained", sb.size(), 0);
    check("bounce_one_ir_load", n_irl - irl0, 1);

    // randomized valid instructions with random holds and glitches
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      v[7:6] = 2'($urandom_range(0, 2));
      step_instr(v, $urandom_range(DB, 10), $urandom_range(0, 3));
    end

    // a second step pulse landing in DECODE is dropped
    do_reset();
    v = 8'($urandom);
    v[7:6] = 2'($urandom_range(0, 2));
    instr = v;
    irl0 = n_irl;
    c0 = cyc;
    sb.push_back('{at: c0 + 7, waddr: v[5:4], op: v[7:6], cnt: 8'd0});
    step_btn = 1'b1;
    tick(4);
    run_mode = 1'b1;
    tick(1);
    run_mode = 1'b0;
    tick(1);
    step_btn = 1'b0;
    tick(20);
    check("drop_sb_drained", sb.size(), 0);
    check("drop_one_ir_load", n_irl - irl0, 1);
    check("drop_count", instr_count, 1);

    // free-run 256 ADD r1,r1; run_mode cleared during the last FETCH
    do_reset();
    instr = 8'h14;
    c0 = cyc;
    for (int i = 0; i < 256; i++)
      sb.push_back('{at: c0 + 3 + 3 * i, waddr: 2'd1, op: 2'd0, cnt: 8'(i)});
    run_mode = 1'b1;
    tick(1 + 3 * 255);
    check("run_last_fetch", state, 1);
    run_mode = 1'b0;
    tick(6);
    check("run_sb_drained", sb.size(), 0);
    check("run_count_wrapped", instr_count, 0);
    check("run_stopped_idle", state, 0);

    // HALT is sticky until reset
    do_reset();
    irl0 = n_irl;
    instr = 8'hC0;
    step_btn = 1'b1; tick(6);
    step_btn = 1'b0; tick(DB + 12);
    check("halt_state", state, 4);
    check("halt_flag", halted, 1);
    check("halt_count", instr_count, 0);
    step_btn = 1'b1; tick(6);
    step_btn = 1'b0;
    run_mode = 1'b1; tick(20);
    run_mode = 1'b0;
    check("halt_sticky_state", state, 4);
    check("halt_sticky_flag", halted, 1);
    check("halt_one_ir_load", n_irl - irl0, 1);
    check("halt_sticky_count", instr_count, 0);
    do_reset();
    check("halt_rst_state", state, 0);
    check("halt_rst_flag", halted, 0);

    // reset in the FETCH cycle aborts the instruction
    do_reset();
    instr = 8'h92;
    step_btn = 1'b1; tick(4);
    step_btn = 1'b0; tick(3);
    check("abort_in_fetch", state, 1);
    check("abort_ir_load_seen", ir_load, 1);
    rst = 1'b1;
    tick(1);
    check("abort_state", state, 0);
    check("abort_ir_load", ir_load, 0);
    check("abort_reg_we", reg_we, 0);
    check("abort_pc_inc", pc_inc, 0);
    check("abort_count", instr_count, 0);
    rst = 1'b0;
    tick(20);
    check("abort_stays_idle", state, 0);
    check("abort_count_after", instr_count, 0);
    check("abort_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
